shift_byte_collector: RTL
=========================

# shift_byte_collector

Downstream consumer of the 8-bit serial-in shift register. Watches the same `shift_enable` strobe that drives the shift register, counts eight shifts, captures the completed `stored_data` word and queues it in a small first-word-fall-through FIFO. The consumer drains the FIFO over a valid/ready handshake. This turns the shift register's free-running parallel view into discrete, framed bytes.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `shift_enable`  input  1  the same strobe that feeds the shift register; one shift per high-sampled edge.
- `stored_data`  input  8  parallel output of the shift register.
- `sync_clear`  input  1  aborts the partial byte and clears the bit counter; does not touch the FIFO.
- `out_ready`  input  1  consumer accepts `out_data` when high with `out_valid`.
- `out_valid`  output  1  FIFO head is valid.
- `out_data`  output  8  FIFO head word; holds its value while `out_valid && !out_ready`.
- `level`  output  $clog2(DEPTH)+1  number of queued words.
- `overflow`  output  1  sticky; set when a completed byte is dropped; cleared only by reset.

## Operation
- `bit_cnt` (0..7) increments on each edge with `shift_enable`=1. Going from 7 to 0 sets `capture_pend` for exactly one cycle.
- When `capture_pend`=1, the edge writes the current `stored_data` into the FIFO. That value reflects all 8 shifts, even if `shift_enable` stays high.
- `sync_clear`=1 forces `bit_cnt` to 0 and suppresses the carry on that edge. An already-set `capture_pend` still completes.
- Push and pop rules:
  - Pop when `out_valid && out_ready`.
  - Push when `capture_pend`.
  - Full with push and pop in the same cycle: both occur, and `level` is unchanged.
  - Full with push and no pop: the word is dropped, `overflow` is set, and FIFO contents are unchanged.
  - Empty with push: the word appears at the head on the next cycle; no bypass in the same cycle.
- Pointers wrap modulo DEPTH. Full is `level`==DEPTH; empty is `level`==0.
- Reset values:
  - `bit_cnt`=0, `capture_pend`=0.
  - FIFO empty; `out_valid`=0, `level`=0, `overflow`=0.
  - `out_data`=8'h00.
- Asserting reset mid-byte discards the partial count and all queued words.

## Timing
- The 8th shift sample occurs at edge N.
- `capture_pend`=1 after edge N.
- Word is written at edge N+1.
- With an empty FIFO, `out_valid`=1 after edge N+1. Shift-to-output latency is 1 cycle after the completing shift.
- With continuous `shift_enable`, bytes complete every 8 cycles. The FIFO sustains this rate with `out_ready` tied high.
- `out_valid` and `out_data` come directly from registers or RAM head, with no combinational path from `out_ready`.

## Configuration
- `SHIFT_BYTE_COLLECTOR_STATS_EN` defined:
  - Adds output `drop_count` [7:0], which increments on each dropped word and saturates at 8'hFF.
  - Reset value is 0.
- Macro undefined: the port and its counter are absent. `overflow` behaviour is identical either way.

## Structure
- Package `shift_byte_collector_pkg` holds:
  - `WORD_W`=8.
  - `BITS_PER_WORD`=8.
  - typedef `word_t` (logic [WORD_W-1:0]).
  - function returning pointer width from DEPTH.
- Sub-module `byte_collector_fifo`: parameterised FWFT FIFO with push/pop/full/empty/level ports, reused for any word-wide queue.
- The top level holds `bit_cnt`, `capture_pend`, overflow/stats logic, and the FIFO instance.

## Test plan
- Reset, then shift in 8 bits 1,0,1,1,0,0,1,0 with a bench model of the shift register, `out_ready`=1 → `out_valid` pulses one cycle, one cycle after the 8th shift, carrying that model's `stored_data` value.
- Continuous `shift_enable` for 32 cycles, `out_ready`=1 → exactly 4 words output at 8-cycle spacing, `overflow`=0.
- `out_ready`=0, 5 bytes shifted with DEPTH=4 → `level`=4, `overflow`=1, and `drop_count`=1 when STATS_EN is defined. Draining yields the first 4 bytes in order.
- FIFO full and capture coinciding with a pop → `level` stays 4, no drop, and the new word is last in the drain order.
- 5 shifts, `sync_clear`, then 8 shifts → exactly one word, equal to the last 8 bits.
- Reset asserted after 2 queued words and 3 partial shifts → `out_valid`=0, `level`=0, and the next byte needs a full 8 shifts.

Source files
------------

// File: rtl/shift_byte_collector_pkg.sv
// shift_byte_collector: shared widths, word type, pointer-width helper.
// Optional stats build: SHIFT_BYTE_COLLECTOR_STATS_EN adds drop_count.
package shift_byte_collector_pkg;

  localparam int WORD_W        = 8;
  localparam int BITS_PER_WORD = 8;

  typedef logic [WORD_W-1:0] word_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/shift_byte_collector_if.sv
// shift_byte_collector bus: serial-strobe inputs and FWFT drain side.
// drop_count present only with SHIFT_BYTE_COLLECTOR_STATS_EN.
interface shift_byte_collector_if #(
  parameter int DEPTH = 4
);
  import shift_byte_collector_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic          shift_enable;
  word_t         stored_data;
  logic          sync_clear;
  logic          out_ready;
  logic          out_valid;
  word_t         out_data;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef SHIFT_BYTE_COLLECTOR_STATS_EN
  logic [7:0]    drop_count;
`endif

  modport master (
    output shift_enable, stored_data, sync_clear, out_ready,
`ifdef SHIFT_BYTE_COLLECTOR_STATS_EN
    input  drop_count,
`endif
    input  out_valid, out_data, level, overflow
  );

  modport slave (
    input  shift_enable, stored_data, sync_clear, out_ready,
`ifdef SHIFT_BYTE_COLLECTOR_STATS_EN
    output drop_count,
`endif
    output out_valid, out_data, level, overflow
  );

endinterface

// File: rtl/byte_collector_fifo.sv
// byte_collector_fifo: small first-word-fall-through queue.
// Push while full is accepted only when a pop frees the slot.
module byte_collector_fifo
  import shift_byte_collector_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W,
  parameter int PW    = ptr_w(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_do_pop) r_rd <= r_rd + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/shift_byte_collector.sv
// shift_byte_collector: frames 8 shifts into bytes and queues them.
// SHIFT_BYTE_COLLECTOR_STATS_EN adds a saturating drop_count.
module shift_byte_collector
  import shift_byte_collector_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  shift_byte_collector_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(BITS_PER_WORD);

  logic [CW-1:0] r_bit_cnt;
  logic          r_capture_pend;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_drop;
  logic [LW-1:0] w_level;
  word_t         w_rdata;

  assign w_pop  = !w_empty && bus.out_ready;
  assign w_drop = r_capture_pend && w_full && !w_pop;

  // Bit counter; carry out of the last bit arms a one-cycle capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bit_cnt      <= '0;
      r_capture_pend <= 1'b0;
    end else begin
      r_capture_pend <= bus.shift_enable && !bus.sync_clear &&
                        (r_bit_cnt == CW'(BITS_PER_WORD - 1));
      if (bus.sync_clear)        r_bit_cnt <= '0;
      else if (bus.shift_enable) r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // Sticky flag for any completed byte lost to a full queue.
  always_ff @(posedge clk) begin
    if (!reset)      r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

`ifdef SHIFT_BYTE_COLLECTOR_STATS_EN
  logic [7:0] r_drop_count;

  // Saturating count of dropped bytes.
  always_ff @(posedge clk) begin
    if (!reset)
      r_drop_count <= '0;
    else if (w_drop && r_drop_count != 8'hFF)
      r_drop_count <= r_drop_count + 1'b1;
  end

  assign bus.drop_count = r_drop_count;
`endif

  byte_collector_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (r_capture_pend),
    .i_pop   (w_pop),
    .i_wdata (bus.stored_data),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_rdata;
  assign bus.level     = w_level;
  assign bus.overflow  = r_overflow;

endmodule
